// File: rtl/vga_pixel_sink.sv
// FIFO-buffered pixel stream scanned out with VGA sync/blank timing once the FIFO is primed.
// Define VGA_PIXEL_SINK_UNDERFLOW_CNT_EN to build the saturating underflowed-pixel counter.
module vga_pixel_sink #(
  parameter int unsigned H_ACTIVE    = 1280,
  parameter int unsigned H_FP        = 48,
  parameter int unsigned H_SYNC      = 112,
  parameter int unsigned H_BP        = 248,
  parameter int unsigned V_ACTIVE    = 1024,
  parameter int unsigned V_FP        = 1,
  parameter int unsigned V_SYNC      = 3,
  parameter int unsigned V_BP        = 38,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned PRIME_LEVEL = 512
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [23:0] i_RGB,
  input  logic        i_RGB_valid,
  output logic        o_RGB_ready,
  output logic [23:0] o_VGA_RGB,
  output logic        o_VGA_HS,
  output logic        o_VGA_VS,
  output logic        o_VGA_BLANK_N,
  output logic        o_frame_start,
  output logic        o_underflow,
  output logic [15:0] o_underflow_cnt
);
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned CW      = ADDR_W + 1;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam logic [CW-1:0] CntDepth = CW'(DEPTH);
  localparam logic [CW-1:0] CntPrime = CW'(PRIME_LEVEL);

  typedef enum logic [1:0] {StIdle, StPrime, StScan} state_e;

  state_e            state_q;
  logic [23:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [HW-1:0]     h_cnt_q;
  logic [VW-1:0]     v_cnt_q;
  logic              scan, active, hs, vs, push, pop, underflow_px;

  // Ready reads 1 during reset, but push is masked so nothing is stored.
  assign o_RGB_ready  = i_rst | (count_q < CntDepth);
  assign push         = i_RGB_valid & o_RGB_ready & ~i_rst;

  assign scan   = (state_q == StScan);
  assign active = scan && (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
  assign hs     = scan && (32'(h_cnt_q) >= H_ACTIVE + H_FP)
                       && (32'(h_cnt_q) < H_ACTIVE + H_FP + H_SYNC);
  assign vs     = scan && (32'(v_cnt_q) >= V_ACTIVE + V_FP)
                       && (32'(v_cnt_q) < V_ACTIVE + V_FP + V_SYNC);

  assign pop          = active && (count_q != '0);
  assign underflow_px = active && (count_q == '0);

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_RGB;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      o_VGA_RGB     <= '0;
      o_VGA_HS      <= 1'b0;
      o_VGA_VS      <= 1'b0;
      o_VGA_BLANK_N <= 1'b0;
      o_frame_start <= 1'b0;
      o_underflow   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      case (state_q)
        StIdle:  state_q <= StPrime;
        StPrime: if (count_q >= CntPrime) state_q <= StScan;
        default: state_q <= StScan;
      endcase

      if (scan) begin
        if (32'(h_cnt_q) == H_TOTAL - 1) begin
          h_cnt_q <= '0;
          v_cnt_q <= (32'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + 1'b1;
        end else begin
          h_cnt_q <= h_cnt_q + 1'b1;
        end
      end

      // All VGA outputs are registered from the same counter values so they stay aligned.
      o_VGA_RGB     <= pop ? mem_q[rd_ptr_q] : '0;
      o_VGA_HS      <= hs;
      o_VGA_VS      <= vs;
      o_VGA_BLANK_N <= active;
      o_frame_start <= scan && (h_cnt_q == '0) && (v_cnt_q == '0);
      if (underflow_px) o_underflow <= 1'b1;
    end
  end

`ifdef VGA_PIXEL_SINK_UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      uf_cnt_q <= '0;
    end else if (underflow_px && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_q <= uf_cnt_q + 1'b1;
    end
  end

  assign o_underflow_cnt = uf_cnt_q;
`else
  assign o_underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Scoreboard bench for vga_pixel_sink with small timing (H_TOTAL 14, V_TOTAL 7, depth 16).
module tb_vga_pixel_sink;
  logic        clk = 1'b0;
  logic        rst, valid, bp_valid;
  logic [23:0] rgb, bp_rgb;

  logic        ready, hs, vs, blank_n, fs, uf;
  logic [23:0] vga_rgb;
  logic [15:0] uf_cnt;
  logic        bp_ready, bp_hs, bp_vs, bp_blank_n, bp_fs, bp_uf;
  logic [23:0] bp_vga_rgb;
  logic [15:0] bp_uf_cnt;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q[$];
  logic [23:0] bp_q[$];

  always #5 clk = ~clk;

  vga_pixel_sink #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .ADDR_W(4), .PRIME_LEVEL(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_RGB(rgb), .i_RGB_valid(valid), .o_RGB_ready(ready),
    .o_VGA_RGB(vga_rgb), .o_VGA_HS(hs), .o_VGA_VS(vs), .o_VGA_BLANK_N(blank_n),
    .o_frame_start(fs), .o_underflow(uf), .o_underflow_cnt(uf_cnt)
  );

  vga_pixel_sink #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .ADDR_W(4), .PRIME_LEVEL(16)
  ) dut_bp (
    .i_clk(clk), .i_rst(rst), .i_RGB(bp_rgb), .i_RGB_valid(bp_valid), .o_RGB_ready(bp_ready),
    .o_VGA_RGB(bp_vga_rgb), .o_VGA_HS(bp_hs), .o_VGA_VS(bp_vs), .o_VGA_BLANK_N(bp_blank_n),
    .o_frame_start(bp_fs), .o_underflow(bp_uf), .o_underflow_cnt(bp_uf_cnt)
  );

  function automatic logic [23:0] pix(input int p);
    logic [7:0] b;
    b = p[7:0];
    return {b, ~b, b ^ 8'hc3};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the last accepted pixel.
  task automatic drive_pixels(input int first, input int last);
    int   p;
    logic acc;
    p = first;
    while (p <= last) begin
      rgb   = pix(p);
      valid = 1'b1;
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #1;
      if (acc) begin
        exp_q.push_back(pix(p));
        p++;
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; rgb = 24'hdeadbe; bp_valid = 1'b0; bp_rgb = '0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({vga_rgb, hs, vs, blank_n, fs, uf, uf_cnt} !== 45'd0) begin
        bad++;
        $display("FAIL reset_outputs got=%h want=0", {vga_rgb, hs, vs, blank_n, fs, uf, uf_cnt});
      end
      total++;
      if (ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_ready got=%b want=1", ready);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; valid = 1'b0;
  endtask

  // Seven pixels must not start the scan; the eighth starts it and frame_start follows 2 cycles later.
  task automatic test_priming(input int base);
    drive_pixels(base, base + 6);
    repeat (6) begin
      @(negedge clk);
      total++;
      if ({vga_rgb, hs, vs, blank_n, fs} !== 28'd0) begin
        bad++;
        $display("FAIL prime_idle got=%h want=0", {vga_rgb, hs, vs, blank_n, fs});
      end
    end
    @(posedge clk);
    #1;
    drive_pixels(base + 7, base + 7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (fs !== (i == 2)) begin
        bad++;
        $display("FAIL prime_frame_start cyc=%0d got=%b want=%b", i + 1, fs, (i == 2));
      end
    end
    total++;
    if (blank_n !== 1'b1 || vga_rgb !== pix(base)) begin
      bad++;
      $display("FAIL prime_first_pixel got=%b/%h want=1/%h", blank_n, vga_rgb, pix(base));
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_stream();
    fork
      begin
        @(posedge clk);
        #1;
        drive_pixels(9, 32);
      end
      begin
        int          ph, pv;
        logic        ea, eh, ev, ef;
        logic [23:0] er;
        ph = 1; pv = 0;
        for (int i = 0; i < 196; i++) begin
          @(negedge clk);
          ea = (ph < 8) && (pv < 4);
          eh = (ph >= 10) && (ph < 12);
          ev = (pv == 5);
          ef = (ph == 0) && (pv == 0);
          er = '0;
          if (ea && exp_q.size() > 0) er = exp_q.pop_front();
          total++;
          if ({blank_n, hs, vs, fs} !== {ea, eh, ev, ef}) begin
            bad++;
            $display("FAIL stream_sync h=%0d v=%0d got=%b want=%b", ph, pv,
                     {blank_n, hs, vs, fs}, {ea, eh, ev, ef});
          end
          total++;
          if (vga_rgb !== er) begin
            bad++;
            $display("FAIL stream_rgb h=%0d v=%0d got=%h want=%h", ph, pv, vga_rgb, er);
          end
          ph++;
          if (ph == 14) begin
            ph = 0;
            pv = (pv == 6) ? 0 : pv + 1;
          end
        end
      end
    join
  endtask

  task automatic test_backpressure();
    int          p, fs_cyc, acc_cyc;
    logic        acc;
    logic [23:0] er;
    @(posedge clk);
    #1;
    p = 1;
    while (p <= 16) begin
      bp_rgb = pix(p + 100); bp_valid = 1'b1;
      @(negedge clk);
      acc = bp_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        bp_q.push_back(pix(p + 100));
        p++;
      end
    end
    bp_rgb = pix(117);
    fs_cyc = -1; acc_cyc = -1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (cyc < 2) begin
        total++;
        if (bp_ready !== 1'b0) begin
          bad++;
          $display("FAIL bp_ready_full cyc=%0d got=%b want=0", cyc, bp_ready);
        end
      end
      if (bp_fs && fs_cyc < 0) fs_cyc = cyc;
      if (bp_blank_n) begin
        er = (bp_q.size() > 0) ? bp_q.pop_front() : 24'd0;
        total++;
        if (bp_vga_rgb !== er) begin
          bad++;
          $display("FAIL bp_rgb cyc=%0d got=%h want=%h", cyc, bp_vga_rgb, er);
        end
      end
      acc = bp_ready && bp_valid;
      @(posedge clk);
      #1;
      if (acc && acc_cyc < 0) begin
        bp_q.push_back(pix(117));
        acc_cyc = cyc;
        bp_valid = 1'b0;
      end
    end
    total++;
    if (fs_cyc != 2 || acc_cyc != 2) begin
      bad++;
      $display("FAIL bp_accept_timing got=fs%0d/acc%0d want=fs2/acc2", fs_cyc, acc_cyc);
    end
    total++;
    if (bp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_pixels_left got=%0d want=0", bp_q.size());
    end
  endtask

  task automatic test_underflow();
    int          found, nuf, ph, pv;
    logic        ea;
    logic [23:0] er;
    logic [15:0] ecnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    drive_pixels(201, 210);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (fs) found = 1;
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL uf_frame_start_timeout got=none want=pulse");
      return;
    end
    nuf = 0;
    for (int i = 0; i < 98; i++) begin
      if (i > 0) @(negedge clk);
      ph = i % 14; pv = i / 14;
      ea = (ph < 8) && (pv < 4);
      er = '0;
      if (ea) begin
        if (exp_q.size() > 0) er = exp_q.pop_front();
        else nuf++;
      end
`ifdef VGA_PIXEL_SINK_UNDERFLOW_CNT_EN
      ecnt = 16'(nuf);
`else
      ecnt = 16'd0;
`endif
      total++;
      if ({blank_n, vga_rgb} !== {ea, er}) begin
        bad++;
        $display("FAIL uf_pixel h=%0d v=%0d got=%b/%h want=%b/%h", ph, pv, blank_n, vga_rgb, ea, er);
      end
      total++;
      if (uf !== (nuf > 0) || uf_cnt !== ecnt) begin
        bad++;
        $display("FAIL uf_flags h=%0d v=%0d got=%b/%0d want=%b/%0d", ph, pv, uf, uf_cnt,
                 (nuf > 0), ecnt);
      end
    end
`ifdef VGA_PIXEL_SINK_UNDERFLOW_CNT_EN
    ecnt = 16'd22;
`else
    ecnt = 16'd0;
`endif
    total++;
    if (uf !== 1'b1 || uf_cnt !== ecnt) begin
      bad++;
      $display("FAIL uf_frame_end got=%b/%0d want=1/%0d", uf, uf_cnt, ecnt);
    end
  endtask

  task automatic test_midframe_reset();
    int found;
    found = 0;
    for (int i = 0; i < 5 && found == 0; i++) begin
      @(negedge clk);
      if (fs) found = 1;
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL mid_frame_start_timeout got=none want=pulse");
      return;
    end
    // At this point the counters sit at h=1, v=0; 30 edges later they reach h=3, v=2.
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({vga_rgb, hs, vs, blank_n, fs, uf, uf_cnt} !== 45'd0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_outputs got=%h/%b want=0/1",
               {vga_rgb, hs, vs, blank_n, fs, uf, uf_cnt}, ready);
    end
    @(posedge clk);
    #1;
    exp_q.delete();
    test_priming(301);
  endtask

  initial begin
    test_reset();
    test_priming(1);
    test_stream();
    test_backpressure();
    test_underflow();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pixel_sink.md
# vga_pixel_sink

Consumer end of the `Main` render stream. It accepts 24-bit pixels through a valid/ready handshake into an internal FIFO. Once the FIFO is primed, it scans them out with standard VGA sync/blank timing. The block sits between `Main`'s `o_RGB`/`o_RGB_valid` stream and the board DAC. Default timing is 1280x1024@60 Hz at 108 MHz.

## Interface
Parameters:
- `H_ACTIVE`, 1280, visible pixels per line
- `H_FP`, 48, horizontal front porch (clocks)
- `H_SYNC`, 112, horizontal sync width
- `H_BP`, 248, horizontal back porch
- `V_ACTIVE`, 1024, visible lines per frame
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 3, vertical sync width
- `V_BP`, 38, vertical back porch
- `ADDR_W`, 10, FIFO address width; `DEPTH` = 2^`ADDR_W`
- `PRIME_LEVEL`, 512, FIFO occupancy needed to start scanning; legal range 1..`DEPTH`

Ports:
- `i_clk`  in  1  single clock; all logic is on its rising edge
- `i_rst`  in  1  synchronous reset, active-high
- `i_RGB`  in  24  pixel, packed as {R[23:16], G[15:8], B[7:0]}
- `i_RGB_valid`  in  1  pixel present
- `o_RGB_ready`  out  1  FIFO can accept a pixel
- `o_VGA_RGB`  out  24  pixel to DAC
- `o_VGA_HS`  out  1  horizontal sync, active-high
- `o_VGA_VS`  out  1  vertical sync, active-high
- `o_VGA_BLANK_N`  out  1  high during the active region
- `o_frame_start`  out  1  one-cycle pulse aligned with the first active pixel of a frame
- `o_underflow`  out  1  sticky; set when an active pixel found the FIFO empty
- `o_underflow_cnt`  out  16  underflowed-pixel count (see Configuration)

## Operation
- **FIFO**
  - Circular buffer with `ADDR_W+1`-bit count.
  - A push occurs when `i_RGB_valid && o_RGB_ready`.
  - `o_RGB_ready` = (count < `DEPTH`), combinational from the registered count.
  - When full, ready is 0 even if a pop happens in the same cycle.
  - Simultaneous push and pop keeps the count unchanged.
  - Pointers wrap modulo `DEPTH`.
- **State machine**
  - `IDLE` -> `PRIME` on the first cycle after reset.
  - `PRIME` -> `SCAN` on the cycle when count >= `PRIME_LEVEL`.
  - `SCAN` is held until reset; there is no return to `PRIME`.
- **Counters**
  - `h_cnt` runs 0..H_TOTAL-1 and `v_cnt` runs 0..V_TOTAL-1; both advance only in `SCAN`.
  - H_TOTAL = `H_ACTIVE`+`H_FP`+`H_SYNC`+`H_BP`; V_TOTAL is defined the same way from the vertical parameters.
  - `v_cnt` increments when `h_cnt` wraps; `v_cnt` wraps to 0 after V_TOTAL-1.
  - Both counters are 0 on entry to `SCAN`.
- **Region decode**
  - active = (`h_cnt` < `H_ACTIVE`) && (`v_cnt` < `V_ACTIVE`).
  - hs = `H_ACTIVE`+`H_FP` <= `h_cnt` < `H_ACTIVE`+`H_FP`+`H_SYNC`.
  - vs uses the same comparison on `v_cnt` with the vertical parameters.
- **Pop and output**
  - Pop happens on active && count != 0; the head pixel is registered into `o_VGA_RGB`.
  - Active with an empty FIFO:
    - `o_VGA_RGB` = 0
    - `o_underflow` is set
    - no pop
    - scanning continues; there is no resynchronisation
  - Outside the active region, `o_VGA_RGB` = 0.
- **Frame start**: `o_frame_start` = registered (`SCAN` && `h_cnt`==0 && `v_cnt`==0).

## Timing
- **Reset values**
  - All outputs 0: `o_VGA_RGB`, `o_VGA_HS`, `o_VGA_VS`, `o_VGA_BLANK_N`, `o_frame_start`, `o_underflow`, `o_underflow_cnt`.
  - FIFO count 0, state `IDLE`, counters 0.
  - `o_RGB_ready` reads 1 while `i_rst` is high, but pushes are ignored.
- **Latency**
  - All VGA outputs lag the counters by exactly 1 clock, so HS, VS, BLANK_N and RGB stay mutually aligned.
  - Push-to-visibility: a pixel pushed at cycle t can be popped no earlier than t+1.
  - `SCAN` entry to the first active pixel on the outputs is 1 clock.
- **Mid-operation reset**: reset mid-frame discards the FIFO contents and the frame. Outputs return to their reset values on the next edge.
- **Handshake**
  - `i_RGB` is sampled only when the push condition holds.
  - Holding `i_RGB_valid` high against `o_RGB_ready`=0 loses no data.

## Configuration
- `VGA_PIXEL_SINK_UNDERFLOW_CNT_EN` defined:
  - `o_underflow_cnt` increments on every underflowed active pixel.
  - It saturates at 16'hFFFF and clears only on reset.
- Undefined: no counter is built and `o_underflow_cnt` is tied to 0. `o_underflow` behaves identically in both builds.

## Test plan
All scenarios use small parameters: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), `ADDR_W`=4, `PRIME_LEVEL`=8.
- **Reset and priming**
  - Stimulus: hold reset 3 cycles, then push 7 pixels.
  - Required: all outputs 0, state stays `PRIME`, `o_VGA_HS`=0.
  - Push the 8th pixel: `SCAN` is entered, and `o_frame_start` pulses 2 cycles after that push.
- **Continuous stream**
  - Stimulus: push pixels 1..32 with continuous valid.
  - Required per line: pixels appear in order with `o_VGA_BLANK_N`=1 for 8 consecutive clocks, then HS high exactly on output clocks 10-11 of the line.
  - Required per frame: VS high during line 5 only; `o_frame_start` repeats every 98 clocks.
- **Backpressure**
  - Stimulus: push 16 pixels while in `PRIME` with `PRIME_LEVEL`=16.
  - Required: `o_RGB_ready`=0 once count=16, and the held 17th pixel is accepted right after the first pop with no loss or duplication.
- **Underflow**
  - Stimulus: supply only 10 pixels in total.
  - Required: pixels 9-10 appear, then the remaining active pixels are 0, `o_underflow`=1, and `o_underflow_cnt`=22 at the end of frame 1 (macro on) or 0 (macro off).
- **Mid-frame reset**
  - Stimulus: assert `i_rst` at `h_cnt`=3, `v_cnt`=2 for 1 cycle.
  - Required: the next edge shows all outputs 0 and count 0, and re-priming requires 8 new pixels.
